logical_issue: RTL and testbench

Issue/collect front-end that drives the 32-bit logical unit (AND/OR/XOR). Accepts logical requests over a valid/ready handshake and decodes a 3-bit function code into the unit's 2-bit ops encoding. Holds one request in an issue register that drives the unit's operand ports, and captures the unit's combinational result into a response FIFO. Returns tagged results over a second valid/ready handshake.

---
 rtl/logical_issue.sv | 159 +++++++++++++++
 tb/tb_logical_issue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/logical_issue.sv
// Issue/collect front-end for the 32-bit logical unit.
// Requests are decoded into the unit's ops encoding, held in a single issue
// register that drives the unit, and the unit's combinational result is
// captured into a small response FIFO returned over a valid/ready handshake.
module logical_issue #(
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 2,
  parameter int ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_func,
  input  logic [31:0]         req_a,
  input  logic [31:0]         req_b,
  input  logic [TAG_W-1:0]    req_tag,
  output logic [31:0]         lu_op1,
  output logic [31:0]         lu_op2,
  output logic [1:0]          lu_ops,
  input  logic [31:0]         lu_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                rsp_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

  // Logical unit ops encoding.
  typedef enum logic [1:0] {
    OPS_ZERO = 2'b00,
    OPS_OR   = 2'b01,
    OPS_XOR  = 2'b10,
    OPS_AND  = 2'b11
  } ops_e;

  // Issue register.
  logic             s1_v;
  logic [31:0]      s1_a;
  logic [31:0]      s1_b;
  ops_e             s1_ops;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_err;

  // Response FIFO.
  logic [31:0]      mem_data [RSP_DEPTH];
  logic [TAG_W-1:0] mem_tag  [RSP_DEPTH];
  logic             mem_err  [RSP_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_count;

  ops_e        dec_ops;
  logic        dec_err;
  logic        accept;
  logic        pop;
  logic        advance;
  logic [31:0] push_data;

  // Decode the function code into the unit's ops encoding and an illegal flag.
  always_comb begin
    // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
    dec_ops = OPS_ZERO;
    dec_err = 1'b0;
    case (req_func)
      3'b000:  dec_ops = OPS_AND;
      3'b001:  dec_ops = OPS_OR;
      3'b010:  dec_ops = OPS_XOR;
      3'b011:  dec_ops = OPS_ZERO;
      default: dec_err = 1'b1;
    endcase
  end

  // The issue register moves into the FIFO when there is room, or when a pop
  // frees an entry at the same edge; a free or draining register takes a new request.
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign advance   = s1_v && ((fifo_count < DEPTH_C) || pop);
  assign req_ready = !s1_v || advance;
  assign accept    = req_valid && req_ready;

  // ZERO and illegal codes both leave ops at 00; their result is defined as 0
  // regardless of what the unit produces for that encoding.
  assign push_data = (s1_ops == OPS_ZERO) ? 32'h0 : lu_out;

  assign lu_op1 = s1_v ? s1_a : 32'h0;
  assign lu_op2 = s1_v ? s1_b : 32'h0;
  assign lu_ops = s1_v ? s1_ops : OPS_ZERO;

  // Issue register: load on request handshake, empty when it advances alone.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      // NOTE: sequential state always uses non-blocking assignments.
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_ops <= OPS_ZERO;
      s1_tag <= '0;
      s1_err <= 1'b0;
    end else if (accept) begin
      s1_v   <= 1'b1;
      s1_a   <= req_a;
      s1_b   <= req_b;
      s1_ops <= dec_ops;
      s1_tag <= req_tag;
      s1_err <= dec_err;
    end else if (advance) begin
      s1_v <= 1'b0;
    end
  end

  // FIFO storage written at the tail on advance.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; outputs are gated by rsp_valid,
    // so stale contents are never visible.
    if (advance) begin
      mem_data[wr_ptr] <= push_data;
      mem_tag[wr_ptr]  <= s1_tag;
      mem_err[wr_ptr]  <= s1_err;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (advance) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({advance, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Saturating count of accepted illegal requests.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_count <= '0;
    end else if (accept && dec_err && (err_count != '1)) begin
      err_count <= err_count + ERRCNT_W'(1);
    end
  end

  assign rsp_data = rsp_valid ? mem_data[rd_ptr] : 32'h0;
  assign rsp_tag  = rsp_valid ? mem_tag[rd_ptr]  : '0;
  assign rsp_err  = rsp_valid ? mem_err[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_logical_issue.sv
// Self-checking bench for logical_issue: directed and random requests are
// compared every cycle against a transaction-level model of outstanding requests.
module tb_logical_issue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        nreset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_func;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic [31:0] lu_op1;
  logic [31:0] lu_op2;
  logic [1:0]  lu_ops;
  logic [31:0] lu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [7:0]  err_count;

  logical_issue #(.TAG_W(4), .RSP_DEPTH(DEPTH), .ERRCNT_W(8)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .lu_op1(lu_op1), .lu_op2(lu_op2), .lu_ops(lu_ops), .lu_out(lu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Logical unit. Its output for ops 00 is arbitrary on purpose: the design
  // must not rely on it.
  assign lu_out = (lu_ops == 2'b11) ? (lu_op1 & lu_op2) :
                  (lu_ops == 2'b01) ? (lu_op1 | lu_op2) :
                  (lu_ops == 2'b10) ? (lu_op1 ^ lu_op2) :
                                      (lu_op1 ^ 32'hA5A5_A5A5);

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  ops;
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
    int          acc;   // edge number at which the request was accepted
  } ent_t;

  ent_t q[$];          // accepted, not yet returned, oldest first
  int   cyc    = 0;
  int   errcnt = 0;
  int   total  = 0;
  int   bad    = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic ent_t make_ent(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b, input logic [3:0] t);
    ent_t e;
    e.a = a; e.b = b; e.tag = t; e.err = 1'b0; e.acc = 0;
    case (f)
      3'd0:    begin e.ops = 2'b11; e.data = a & b; end
      3'd1:    begin e.ops = 2'b01; e.data = a | b; end
      3'd2:    begin e.ops = 2'b10; e.data = a ^ b; end
      3'd3:    begin e.ops = 2'b00; e.data = 32'h0; end
      default: begin e.ops = 2'b00; e.data = 32'h0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // One clock cycle: drive, check all outputs against the model, clock, update model.
  task automatic step(input logic v, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] t, input logic rr,
                      output logic acc);
    int   n;
    logic m_rsp_v, m_pop, m_ready, m_s1;
    ent_t e;
    req_valid = v; req_func = f; req_a = a; req_b = b; req_tag = t; rsp_ready = rr;
    #1;
    n = q.size();
    // The oldest outstanding request is visible one edge after acceptance.
    m_rsp_v = (n > 0) && (q[0].acc != cyc);
    m_pop   = m_rsp_v && rr;
    // Capacity is the FIFO plus the issue register.
    m_ready = (n <= DEPTH) || m_pop;
    // The newest request sits in the issue register if it just arrived or the FIFO is full.
    m_s1    = (n > 0) && ((q[n-1].acc == cyc) || (n > DEPTH));
    check("req_ready", {31'b0, req_ready}, {31'b0, m_ready});
    check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_rsp_v});
    check("rsp_data",  rsp_data, m_rsp_v ? q[0].data : 32'h0);
    check("rsp_tag",   {28'b0, rsp_tag}, m_rsp_v ? {28'b0, q[0].tag} : 32'h0);
    check("rsp_err",   {31'b0, rsp_err}, m_rsp_v ? {31'b0, q[0].err} : 32'h0);
    check("lu_op1",    lu_op1, m_s1 ? q[n-1].a : 32'h0);
    check("lu_op2",    lu_op2, m_s1 ? q[n-1].b : 32'h0);
    check("lu_ops",    {30'b0, lu_ops}, m_s1 ? {30'b0, q[n-1].ops} : 32'h0);
    check("err_count", {24'b0, err_count}, errcnt);
    acc = v && m_ready;
    @(posedge clk);
    cyc++;
    if (m_pop) void'(q.pop_front());
    if (acc) begin
      e = make_ent(f, a, b, t);
      e.acc = cyc;
      q.push_back(e);
      if (e.err && errcnt < 255) errcnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rr);
    logic acc;
    step(1'b0, 3'd0, 32'h0, 32'h0, 4'h0, rr, acc);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) idle(1'b1);
    idle(1'b1);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    req_valid = 1'b0;
    #2 nreset = 1'b0;
    #1;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_data",  rsp_data, 32'h0);
    check("rst_lu_ops",    {30'b0, lu_ops}, 32'h0);
    check("rst_lu_op1",    lu_op1, 32'h0);
    check("rst_err_count", {24'b0, err_count}, 32'h0);
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    q.delete();
    errcnt = 0;
    @(negedge clk);
    #2 nreset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    nreset = 1'b0; req_valid = 1'b0; req_func = 3'd0; req_a = '0; req_b = '0;
    req_tag = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;

    // Reset state.
    idle(1'b0);

    // Single AND/OR/XOR requests, A=7 B=6.
    for (int f = 0; f < 3; f++) begin
      step(1'b1, 3'(f), 32'd7, 32'd6, 4'(f + 1), 1'b1, acc);
      idle(1'b1); idle(1'b1);
    end

    // Illegal and ZERO codes.
    step(1'b1, 3'b101, 32'hFFFF_FFFF, 32'h1234_5678, 4'd3, 1'b1, acc);
    idle(1'b1); idle(1'b1);
    check("err_count_one", {24'b0, err_count}, 32'd1);
    step(1'b1, 3'b011, 32'hFFFF_0000, 32'h00FF_FF00, 4'd5, 1'b1, acc);
    idle(1'b1); idle(1'b1);

    // Saturation of the illegal counter.
    for (int i = 0; i < 300; i++)
      step(1'b1, 3'(4 + (i % 4)), $urandom, $urandom, 4'(i), 1'b1, acc);
    drain();
    check("err_count_sat", {24'b0, err_count}, 32'd255);

    // Backpressure: tags 0-2 fill the pipeline, tag 3 waits, then
    // simultaneous pop and push at full.
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'd2, 32'h100 + i, 32'hF0, 4'(i), 1'b0, acc);
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'd2, 32'h103, 32'hF0, 4'd3, 1'b0, acc);
    step(1'b1, 3'd2, 32'h103, 32'hF0, 4'd3, 1'b1, acc);
    step(1'b1, 3'd0, 32'hFFFF, 32'h0F0F, 4'd4, 1'b0, acc);
    idle(1'b0); idle(1'b0);
    drain();

    // Streaming XOR, one per cycle.
    for (int i = 0; i < 16; i++)
      step(1'b1, 3'd2, 32'(i), 32'hF, 4'(i), 1'b1, acc);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom, $urandom,
           4'($urandom), 1'($urandom_range(0, 3) != 0), acc);
    drain();

    // Async reset with three requests pending.
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'd1, 32'h10 << i, 32'h1, 4'(8 + i), 1'b0, acc);
    step(1'b1, 3'd6, 32'h1, 32'h1, 4'd12, 1'b0, acc);
    async_reset();
    for (int i = 0; i < 4; i++) idle(1'b1);
    step(1'b1, 3'd0, 32'hDEAD_BEEF, 32'hFFFF_0000, 4'd9, 1'b1, acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
